// File: rtl/pc_fetch_stage_pkg.sv
// Shared CPU constants and the IF/ID bundle used by the fetch stage.
// Anything the next pipeline stage consumes from fetch lives here.
package pc_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/pc_fetch_stage_npc_sel.sv
// Next-PC selection: fixed-priority redirect mux, word alignment of
// the chosen target and a misalignment flag for the chosen target.
module npc_sel
    import pc_fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        j_i,
    input  logic [31:0] j_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] npc_o,
    output logic        misalign_o
);

    logic        redir;
    logic [31:0] raw;

    always_comb begin
        redir = 1'b1;
        raw   = '0;
        if (jr_i) begin
            raw = jr_target_i;
        end else if (j_i) begin
            raw = j_target_i;
        end else if (br_taken_i) begin
            raw = br_target_i;
        end else begin
            redir = 1'b0;
        end
    end

    assign npc_o      = redir ? word_align(raw) : pc_i + PC_INC;
    assign misalign_o = redir & (raw[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register and fetch counter.
// Delayed-branch pipeline, so a redirect never flushes IF/ID.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        j_i,
    input  logic [31:0] j_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    logic [31:0] pc_q, pc_d;
    if_id_t      ifid_q, ifid_d;
    logic        mis_q, mis_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] npc;
    logic        npc_mis;

    npc_sel u_npc_sel (
        .pc_i        (pc_q),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .j_i         (j_i),
        .j_target_i  (j_target_i),
        .jr_i        (jr_i),
        .jr_target_i (jr_target_i),
        .npc_o       (npc),
        .misalign_o  (npc_mis)
    );

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        mis_d  = mis_q;
        cnt_d  = cnt_q;
        if (!stall_i) begin
            pc_d         = npc;
            ifid_d.instr = imem_instr_i;
            ifid_d.pc    = pc_q;
            ifid_d.valid = 1'b1;
            mis_d        = npc_mis;
            // Counter saturates rather than wrapping.
            cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_q.instr <= NOP_WORD;
            ifid_q.pc    <= RESET_PC;
            ifid_q.valid <= 1'b0;
            mis_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            mis_q  <= mis_d;
            cnt_q  <= cnt_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_pc4_o   = ifid_q.pc + PC_INC;
    assign ifid_valid_o = ifid_q.valid;
    assign misalign_o   = mis_q;
    assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed literal cases plus
// randomized traffic compared each cycle against a behavioural model.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        j_i = 1'b0;
    logic [31:0] j_target_i = '0;
    logic        jr_i = 1'b0;
    logic [31:0] jr_target_i = '0;
    logic [31:0] imem_instr_i;
    logic [31:0] imem_addr_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    pc_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .j_i          (j_i),
        .j_target_i   (j_target_i),
        .jr_i         (jr_i),
        .jr_target_i  (jr_target_i),
        .imem_instr_i (imem_instr_i),
        .imem_addr_o  (imem_addr_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_valid_o (ifid_valid_o),
        .misalign_o   (misalign_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_instr_i = mem_word(imem_addr_o);

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_pc, m_instr, m_ifpc, m_cnt;
    logic        m_valid, m_mis;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_instr = 32'h0000_0000;
        m_ifpc  = 32'h0000_3000;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_cnt   = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc",      imem_addr_o,  m_pc);
            chk("instr",   ifid_instr_o, m_instr);
            chk("ifid_pc", ifid_pc_o,    m_ifpc);
            chk("pc4",     ifid_pc4_o,   m_ifpc + 32'd4);
            chk("valid",   {31'd0, ifid_valid_o}, {31'd0, m_valid});
            chk("mis",     {31'd0, misalign_o},   {31'd0, m_mis});
            chk("cnt",     fetch_cnt_o,  m_cnt);
        end
    end

    // Apply one cycle of inputs, clock it, then advance the model.
    task automatic cycle(input bit st, input bit br, input logic [31:0] brt,
                         input bit j, input logic [31:0] jt,
                         input bit jr, input logic [31:0] jrt);
        logic [31:0] t;
        bit          redir;
        stall_i = st; br_taken_i = br; br_target_i = brt;
        j_i = j; j_target_i = jt; jr_i = jr; jr_target_i = jrt;
        @(posedge clk);
        if (!st) begin
            redir = jr | j | br;
            t = jr ? jrt : (j ? jt : brt);
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_cnt   = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
            m_mis   = redir && (t % 4 != 0);
            m_pc    = redir ? t - (t % 4) : m_pc + 4;
        end
        #1;
    endtask

    task automatic plain();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pc",    imem_addr_o, 32'h0000_3000);
        chk("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("rst_cnt",   fetch_cnt_o, 32'd0);
        chk("rst_ifpc",  ifid_pc_o, 32'h0000_3000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        cmp_en = 1'b1;
        do_reset();

        plain();
        chk("s1_pc", imem_addr_o, 32'h0000_3004);
        chk("s1_ifpc", ifid_pc_o, 32'h0000_3000);
        chk("s1_valid", {31'd0, ifid_valid_o}, 32'd1);
        plain();
        chk("s2_pc", imem_addr_o, 32'h0000_3008);
        chk("s2_ifpc", ifid_pc_o, 32'h0000_3004);
        plain();
        chk("s3_pc", imem_addr_o, 32'h0000_300C);
        chk("s3_ifpc", ifid_pc_o, 32'h0000_3008);
        chk("s3_cnt", fetch_cnt_o, 32'd3);

        do_reset();
        plain();
        plain();
        chk("br_pre", imem_addr_o, 32'h0000_3008);
        cycle(0, 1, 32'h0000_3040, 0, 0, 0, 0);
        chk("br_pc", imem_addr_o, 32'h0000_3040);
        chk("br_slot_pc", ifid_pc_o, 32'h0000_3008);
        chk("br_slot_ins", ifid_instr_o, mem_word(32'h0000_3008));

        cycle(1, 1, 32'h0000_3080, 0, 0, 0, 0);
        cycle(1, 1, 32'h0000_3080, 0, 0, 0, 0);
        chk("st_pc", imem_addr_o, 32'h0000_3040);
        chk("st_ifpc", ifid_pc_o, 32'h0000_3008);
        chk("st_cnt", fetch_cnt_o, 32'd3);
        cycle(0, 1, 32'h0000_3080, 0, 0, 0, 0);
        chk("rel_pc", imem_addr_o, 32'h0000_3080);
        plain();
        chk("rel2_pc", imem_addr_o, 32'h0000_3084);

        cycle(0, 1, 32'h0000_5000, 1, 32'h0000_4000, 1, 32'h0000_3101);
        chk("jr_pc", imem_addr_o, 32'h0000_3100);
        chk("jr_mis", {31'd0, misalign_o}, 32'd1);
        plain();
        chk("jr_mis0", {31'd0, misalign_o}, 32'd0);

        cycle(0, 1, 32'h0000_5000, 1, 32'h0000_4002, 0, 0);
        chk("j_pc", imem_addr_o, 32'h0000_4000);
        cycle(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        plain();
        chk("wrap_pc", imem_addr_o, 32'h0000_0000);
        chk("wrap_pc4", ifid_pc4_o, 32'h0000_0000);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                rt = $urandom;
                if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
                cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 5) == 0, $urandom,
                      $urandom_range(0, 7) == 0, rt,
                      $urandom_range(0, 9) == 0, $urandom);
            end
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word loaded into IF/ID on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 stall_i  input  1  hazard-unit stall; freezes PC and IF/ID.
REQ-006 br_taken_i  input  1  branch decision from the ID-stage branch AND gate (branch op AND compare result).
REQ-007 br_target_i  input  32  branch target (PC+4 of branch + sign-extended offset<<2), computed in ID.
REQ-008 j_i  input  1  j/jal in ID.
REQ-009 j_target_i  input  32  jump target {pc4[31:28], instr_index, 2'b00}.
REQ-010 jr_i  input  1  jr/jalr in ID.
REQ-011 jr_target_i  input  32  forwarded register value for jr.
REQ-012 imem_instr_i  input  32  instruction word at imem_addr_o (combinational instruction memory).
REQ-013 imem_addr_o  output  32  current PC.
REQ-014 ifid_instr_o  output  32  IF/ID instruction register.
REQ-015 ifid_pc_o  output  32  IF/ID PC of held instruction.
REQ-016 ifid_pc4_o  output  32  ifid_pc_o + 4.
REQ-017 ifid_valid_o  output  1  IF/ID holds a fetched instruction (0 after reset until first fetch).
REQ-018 misalign_o  output  1  registered flag: an accepted redirect target had bits [1:0] != 0.
REQ-019 fetch_cnt_o  output  32  count of instructions latched into IF/ID since reset.

Function
REQ-020 Next PC, evaluated combinationally: jr_i -> jr_target_i; else j_i -> j_target_i; else br_taken_i -> br_target_i; else PC+4 (fixed priority when several asserted).
REQ-021 On each rising edge with stall_i=0: PC <= next PC; IF/ID <= {imem_instr_i, PC}; ifid_valid_o <= 1; fetch_cnt_o increments by 1.
REQ-022 With stall_i=1: PC, IF/ID, ifid_valid_o, fetch_cnt_o hold; redirect inputs ignored (re-presented by ID next cycle).
REQ-023 Delayed-branch semantics: instruction at PC following a branch/jump (delay slot) is fetched and passed on; IF/ID is never flushed by a redirect.
REQ-024 Redirect target bits [1:0] forced to 00 before loading PC; misalign_o <= 1 on an accepted redirect with nonzero [1:0], else 0 on every unstalled edge.
REQ-025 All PC arithmetic is 32-bit modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 0.
REQ-026 fetch_cnt_o saturates at 32'hFFFF_FFFF (no wrap).
REQ-027 ifid_pc4_o is combinational from ifid_pc_o; imem_addr_o is PC register directly (no extra latency); fetch-to-IF/ID latency is 1 cycle.

Reset
REQ-028 rst_n low asynchronously sets PC=RESET_PC, ifid_instr_o=NOP_WORD, ifid_pc_o=RESET_PC, ifid_valid_o=0, misalign_o=0, fetch_cnt_o=0.
REQ-029 Reset asserted mid-stall or mid-redirect overrides everything; first edge after rst_n rises behaves as REQ-021 from RESET_PC.

Structure
REQ-030 RESET_PC default, NOP_WORD default, and the PC increment constant (4) live in the shared CPU package.
REQ-031 Next-PC selection (REQ-020, REQ-024) is a combinational sub-module npc_sel; PC and IF/ID registers remain in pc_fetch_stage.

Verification
REQ-032 Reset then 3 unstalled cycles -> imem_addr_o 3000,3004,3008,300C; ifid_pc_o 3000,3004,3008; fetch_cnt_o=3; ifid_valid_o=1 from cycle 1.
REQ-033 br_taken_i=1, br_target_i=0000_3040 at PC=3008 -> next PC 3040; IF/ID still receives instruction at 3008 (delay slot, no flush).
REQ-034 stall_i=1 for 2 cycles with br_taken_i=1 -> PC and IF/ID unchanged, fetch_cnt_o unchanged; after release redirect taken once.
REQ-035 jr_i=1 (target 0000_3101), j_i=1, br_taken_i=1 same cycle -> PC=0000_3100, misalign_o=1 next cycle, 0 cycle after.
REQ-036 rst_n dropped between edges mid-run -> outputs reach reset values immediately, PC=3000 without a clock edge.
